uart_rx_parity: RTL and testbench

//  Receive half of the board's 9600-baud UART link. Samples rx_line at mid-bit and deframes:

---
 rtl/uart_rx_parity.sv | 154 +++++++++++++++
 tb/tb_uart_rx_parity.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_parity.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop; mid-bit sampling.
// Delivers each byte with a one-cycle rx_valid strobe plus parity and framing status.
module uart_rx_parity #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rxs;
  logic                   fall;
  logic [CW-1:0]          baud_cnt;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift_q;
  logic                   par_bit;
  logic                   tick;

  logic          cnt_load;
  logic [CW-1:0] cnt_ld_val;
  logic          shift_en;
  logic          bit_clr;
  logic          bit_inc;
  logic          par_en;
  logic          done;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~rxs;
  // Down-counter loaded with N-1 so the tick lands exactly N cycles after the load.
  assign tick = (baud_cnt == '0);
  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_line};
      prev_q <= rxs;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_ld_val = FULL_LD;
    shift_en   = 1'b0;
    bit_clr    = 1'b0;
    bit_inc    = 1'b0;
    par_en     = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d    = S_START;
          cnt_load   = 1'b1;
          cnt_ld_val = HALF_LD;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_load = 1'b1;
          if (!rxs) begin
            state_d = S_DATA;
            bit_clr = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
          if (bit_cnt == 4'd7) state_d = S_PARITY;
          else                 bit_inc = 1'b1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          par_en   = 1'b1;
          cnt_load = 1'b1;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          done     = 1'b1;
          cnt_load = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_bit    <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_valid   <= 1'b0;
    end else begin
      if (cnt_load)           baud_cnt <= cnt_ld_val;
      else if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;

      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 4'd1;

      if (shift_en) shift_q <= {rxs, shift_q[7:1]};
      if (par_en)   par_bit <= rxs;

      rx_valid <= done;
      if (done) begin
        data       <= shift_q;
        parity_err <= (^shift_q) ^ par_bit;
        frame_err  <= ~rxs;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Scoreboard bench for uart_rx_parity: frames push expected results, the rx_valid
// monitor pops and compares them.
module tb_uart_rx_parity;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int SYNC = 2;
  localparam int TCLK = 10;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_line;
  logic [7:0] data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  logic [9:0] sb[$];
  time        pulse_t[$];
  time        t_edge;
  int         vectors     = 0;
  int         miscompares = 0;
  int         pulse_cnt   = 0;
  logic       prev_v      = 1'b0;

  uart_rx_parity #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HALF),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_line   (rx_line),
    .data      (data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #(TCLK / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [9:0] e;
    if (rx_valid) begin
      check("valid_not_consecutive", 32'(prev_v), 32'd0);
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("frame_result", 32'({data, parity_err, frame_err}), 32'(e));
      end
      pulse_cnt++;
      pulse_t.push_back($time);
    end
    prev_v = rx_valid;
  end

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    sb.push_back({d, (^d) ^ par, ~stp});
    t_edge = $time;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(data), 32'h00);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_perr"}, 32'(parity_err), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #(TCLK * 50000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gap;
    int busy_seen;
    int n;

    n_rst   = 1'b0;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    n_rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);

    // Clean frame, plus edge-to-strobe latency
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_pulses", 32'(pulse_cnt), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    lat = (pulse_t.size() != 0) ? int'((pulse_t[pulse_t.size()-1] - t_edge) / TCLK) : 0;
    check("t1_latency", 32'(lat >= SYNC + HALF + 10 * CPB && lat <= SYNC + 2 + HALF + 10 * CPB), 32'd1);

    // Parity error, then cleared by a good frame
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_perr_set", 32'(parity_err), 32'd1);
    drive_bit(1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_perr_clear", 32'(parity_err), 32'd0);
    check("t2_pulses", 32'(pulse_cnt), 32'd3);

    // Frame error followed by a break: no retrigger while low
    send_frame(8'h3C, 1'b0, 1'b0);
    busy_seen = 0;
    repeat (40 * CPB) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("t3_no_retrigger", 32'(busy_seen), 32'd0);
    check("t3_pulses", 32'(pulse_cnt), 32'd4);
    check("t3_ferr_held", 32'(frame_err), 32'd1);
    rx_line = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t3_idle_after_rise", 32'(busy), 32'd0);

    // Short low glitch on the idle line
    busy_seen = 0;
    rx_line = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    rx_line = 1'b1;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("t4_busy_pulsed", 32'(busy_seen != 0), 32'd1);
    check("t4_busy_low", 32'(busy), 32'd0);
    check("t4_pulses", 32'(pulse_cnt), 32'd4);
    check("t4_outputs_held", 32'({data, parity_err, frame_err}), 32'({8'h3C, 1'b0, 1'b1}));

    // Back-to-back frames; start + 8 data + parity + stop = 11 bit periods apart
    n = pulse_t.size();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_pulses", 32'(pulse_cnt), 32'd6);
    gap = (pulse_t.size() >= n + 2) ? int'((pulse_t[n+1] - pulse_t[n]) / TCLK) : 0;
    check("t5_spacing", 32'(gap >= 11 * CPB - 1 && gap <= 11 * CPB + 1), 32'd1);

    // Reset during d4 of 0x81 discards the partial frame
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(n[0] ? 1'b0 : (8'h81 >> i) & 1'b1);
    rx_line = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    n_rst   = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("t6_in_reset");
    n_rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_reset_outputs("t6_after_reset");
    check("t6_no_abort_pulse", 32'(pulse_cnt), 32'd6);
    send_frame(8'h7E, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_pulses", 32'(pulse_cnt), 32'd7);
    check("t6_busy_low", 32'(busy), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
